iob_cache_be_arbiter: RTL and testbench
=======================================

IOB_CACHE_BE_ARBITER -- requirements
Module: iob_cache_be_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 26, line-address width compared for hazards.
REQ-002 The block SHALL have parameter STARVE_W, default 4, starvation counter width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 8, consecutive replace grants tolerated while a write is pending; 1 <= MAX_WAIT <= 2**STARVE_W-1.
REQ-004 The block SHALL have port clk_i  input  1  system clock, all state on rising edge.
REQ-005 The block SHALL have port rst_i  input  1  system reset, asynchronous and active-high.
REQ-006 The block SHALL have port wr_valid_i  input  1  write-through buffer requests a back-end write.
REQ-007 The block SHALL have port wr_addr_i  input  ADDR_W  line address of pending write.
REQ-008 The block SHALL have port wr_ready_o  output  1  one-cycle completion pulse to write requester.
REQ-009 The block SHALL have port rep_valid_i  input  1  cache requests a line replacement.
REQ-010 The block SHALL have port rep_addr_i  input  ADDR_W  line address to fill.
REQ-011 The block SHALL have port rep_done_o  output  1  one-cycle completion pulse to replace requester.
REQ-012 The block SHALL have port be_wr_valid_o  output  1  enables back-end write channel.
REQ-013 The block SHALL have port be_wr_ready_i  input  1  back-end write channel completion pulse.
REQ-014 The block SHALL have port be_rep_valid_o  output  1  enables back-end read (line fill) channel.
REQ-015 The block SHALL have port be_rep_done_i  input  1  back-end line fill completion pulse.
REQ-016 The block SHALL have port starve_cnt_o  output  STARVE_W  current starvation count (debug).

Function
REQ-017 FSM states SHALL be IDLE, WR, REP; encoding registered.
REQ-018 In IDLE with only wr_valid_i high, next state SHALL be WR; only rep_valid_i high, next state REP; neither, stay IDLE.
REQ-019 In IDLE with both valid, REP SHALL win unless starve_cnt == MAX_WAIT (or hazard per REQ-031), in which case WR wins.
REQ-020 Grant latency SHALL be exactly one cycle: valid sampled in IDLE, be_*_valid_o high the following cycle.
REQ-021 be_wr_valid_o SHALL equal (state==WR); be_rep_valid_o SHALL equal (state==REP); never both high.
REQ-022 In WR, be_wr_ready_i high SHALL drive wr_ready_o high combinationally that cycle and return to IDLE next cycle.
REQ-023 In REP, be_rep_done_i high SHALL drive rep_done_o high combinationally that cycle and return to IDLE next cycle.
REQ-024 be_wr_ready_i outside WR and be_rep_done_i outside REP SHALL be ignored (no pulse, no transition).
REQ-025 A grant SHALL be held until its completion even if the requester's valid drops (requester holds valid until completion by protocol).
REQ-026 At least one IDLE cycle SHALL separate consecutive grants; requests arriving with a completion are evaluated in that IDLE cycle.
REQ-027 starve_cnt SHALL increment by one on each IDLE->REP transition taken while wr_valid_i is high, saturating at MAX_WAIT.
REQ-028 starve_cnt SHALL clear to 0 on every IDLE->WR transition; otherwise hold.

Reset
REQ-029 On rst_i high, state SHALL become IDLE and starve_cnt 0 asynchronously; all outputs 0; no completion pulse emitted for an aborted grant.
REQ-030 After rst_i deasserts, first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-031 With IOB_CACHE_BE_ARB_HAZARD_EN defined, in IDLE with both valid and wr_addr_i == rep_addr_i, WR SHALL win regardless of starve_cnt (line fill sees fresh data); without it, no address comparison exists and REQ-019 alone decides.

Verification
REQ-032 Only wr_valid_i=1 at cycle 0 -> be_wr_valid_o=1 from cycle 1; be_wr_ready_i pulse at cycle 5 -> wr_ready_o=1 at cycle 5, state IDLE at cycle 6.
REQ-033 Both valid, distinct addresses, starve_cnt=0 -> REP granted; starve_cnt=1 after grant; wr_valid_i untouched.
REQ-034 MAX_WAIT=2, both valid continuously, 2-cycle completions -> grant order REP, REP, WR, REP; starve_cnt 1,2,0,1.
REQ-035 Both valid, wr_addr_i=rep_addr_i=0x1234 -> with IOB_CACHE_BE_ARB_HAZARD_EN WR granted first; without it REP granted first.
REQ-036 rst_i pulsed during REP before be_rep_done_i -> be_rep_valid_o=0 immediately, rep_done_o never pulses, starve_cnt=0; late be_rep_done_i ignored.

Source files
------------

// File: rtl/iob_cache_be_arbiter.sv
`default_nettype none
//============================================================================
// Module      : iob_cache_be_arbiter
// Description : Arbitrates the cache back-end between the write-through
//               buffer (writes) and the line-replacement engine (fills).
//               Replacements win by default. A write that has waited through
//               MAX_WAIT consecutive replacement grants is served next.
//
// Ports       : clk_i          - system clock, rising edge
//               rst_i          - asynchronous active-high reset
//               wr_valid_i     - write requester wants the back-end
//               wr_addr_i      - line address of the pending write
//               wr_ready_o     - write completion pulse
//               rep_valid_i    - replace requester wants the back-end
//               rep_addr_i     - line address to fill
//               rep_done_o     - replace completion pulse
//               be_wr_valid_o  - back-end write channel enable
//               be_wr_ready_i  - back-end write completion pulse
//               be_rep_valid_o - back-end fill channel enable
//               be_rep_done_i  - back-end fill completion pulse
//               starve_cnt_o   - current starvation count (debug)
//
// Options     : IOB_CACHE_BE_ARB_HAZARD_EN - when defined, a write to the
//               same line as a pending fill is always served first so the
//               fill reads fresh data.
//
// Revision    : 1.0 - initial release
//============================================================================
module iob_cache_be_arbiter #(
    parameter int ADDR_W   = 26,
    parameter int STARVE_W = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                wr_valid_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    output logic                wr_ready_o,

    input  logic                rep_valid_i,
    input  logic [ADDR_W-1:0]   rep_addr_i,
    output logic                rep_done_o,

    output logic                be_wr_valid_o,
    input  logic                be_wr_ready_i,
    output logic                be_rep_valid_o,
    input  logic                be_rep_done_i,

    output logic [STARVE_W-1:0] starve_cnt_o
);

    localparam logic [1:0]          c_IDLE     = 2'd0;
    localparam logic [1:0]          c_WR       = 2'd1;
    localparam logic [1:0]          c_REP      = 2'd2;
    localparam logic [STARVE_W-1:0] c_MAX_WAIT = STARVE_W'(MAX_WAIT);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [STARVE_W-1:0] r_starve_cnt;
    // Cleared by reset and set on the first edge afterwards, so no grant is
    // decided on the very first rising edge following reset release.
    logic                r_armed;
    logic                w_hazard;
    logic                w_starved;
    logic                w_wr_wins;
    logic                w_go_wr;
    logic                w_go_rep;

`ifdef IOB_CACHE_BE_ARB_HAZARD_EN
    assign w_hazard = (wr_addr_i == rep_addr_i);
`else
    // Addresses only matter for the hazard option; fold them into a sink.
    logic w_unused_addr;
    assign w_unused_addr = ^{wr_addr_i, rep_addr_i};
    assign w_hazard      = 1'b0;
`endif

    assign w_starved = (r_starve_cnt == c_MAX_WAIT);
    assign w_wr_wins = wr_valid_i & (~rep_valid_i | w_starved | w_hazard);

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_armed) begin
                    if (w_wr_wins) begin
                        w_next_state = c_WR;
                    end else if (rep_valid_i) begin
                        w_next_state = c_REP;
                    end
                end
            end
            c_WR: begin
                if (be_wr_ready_i) begin
                    w_next_state = c_IDLE;
                end
            end
            c_REP: begin
                if (be_rep_done_i) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    assign w_go_wr  = (r_state == c_IDLE) && (w_next_state == c_WR);
    assign w_go_rep = (r_state == c_IDLE) && (w_next_state == c_REP);

    //------------------------------------------------------------------------
    // State, arm flag and starvation counter
    //------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= c_IDLE;
            r_starve_cnt <= '0;
            r_armed      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_armed <= 1'b1;
            if (w_go_wr) begin
                r_starve_cnt <= '0;
            end else if (w_go_rep && wr_valid_i && !w_starved) begin
                // Only replacement grants that bypass a waiting write count.
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Outputs: grants follow the state; completions pass through only while
    // the matching grant is active.
    //------------------------------------------------------------------------
    assign be_wr_valid_o  = (r_state == c_WR);
    assign be_rep_valid_o = (r_state == c_REP);
    assign wr_ready_o     = (r_state == c_WR)  & be_wr_ready_i;
    assign rep_done_o     = (r_state == c_REP) & be_rep_done_i;
    assign starve_cnt_o   = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iob_cache_be_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_iob_cache_be_arbiter
// Description : Self-checking bench for iob_cache_be_arbiter. A transaction
//               level model predicts which requester is granted and the
//               starvation count; directed scenarios cover the documented
//               examples and reset abort, then a randomized run follows.
// Revision    : 1.0 - initial release
//============================================================================
module tb_iob_cache_be_arbiter;

    localparam int ADDR_W   = 16;
    localparam int STARVE_W = 3;
    localparam int MAX_WAIT = 2;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                wr_valid_i;
    logic [ADDR_W-1:0]   wr_addr_i;
    logic                wr_ready_o;
    logic                rep_valid_i;
    logic [ADDR_W-1:0]   rep_addr_i;
    logic                rep_done_o;
    logic                be_wr_valid_o;
    logic                be_wr_ready_i;
    logic                be_rep_valid_o;
    logic                be_rep_done_i;
    logic [STARVE_W-1:0] starve_cnt_o;

    int checks       = 0;
    int failures     = 0;
    int model_starve = 0;

    always #5 clk = ~clk;

    iob_cache_be_arbiter #(
        .ADDR_W   (ADDR_W),
        .STARVE_W (STARVE_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wr_valid_i     (wr_valid_i),
        .wr_addr_i      (wr_addr_i),
        .wr_ready_o     (wr_ready_o),
        .rep_valid_i    (rep_valid_i),
        .rep_addr_i     (rep_addr_i),
        .rep_done_o     (rep_done_o),
        .be_wr_valid_o  (be_wr_valid_o),
        .be_wr_ready_i  (be_wr_ready_i),
        .be_rep_valid_o (be_rep_valid_o),
        .be_rep_done_i  (be_rep_done_i),
        .starve_cnt_o   (starve_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    // 0 = nobody, 1 = write, 2 = replace
    function automatic int predict(input bit wv, input bit rv,
                                   input logic [ADDR_W-1:0] wa,
                                   input logic [ADDR_W-1:0] ra);
        if (!wv && !rv) return 0;
        if (wv && !rv)  return 1;
        if (!wv && rv)  return 2;
        if (model_starve == MAX_WAIT) return 1;
`ifdef IOB_CACHE_BE_ARB_HAZARD_EN
        if (wa == ra) return 1;
`else
        if (wa == ra) return 2;
`endif
        return 2;
    endfunction

    function automatic int observed_grant();
        if (be_wr_valid_o === 1'b1)  return 1;
        if (be_rep_valid_o === 1'b1) return 2;
        return 0;
    endfunction

    // One request round: present valids during an IDLE cycle, observe the
    // grant one cycle later, keep it for 'hold' cycles, then complete it.
    task automatic txn(input bit wv, input bit rv,
                       input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra,
                       input int hold, input bit noise,
                       output int grant, output int starve);
        int exp_g;
        int h;
        @(posedge clk); #1;
        wr_valid_i    = wv;
        rep_valid_i   = rv;
        wr_addr_i     = wa;
        rep_addr_i    = ra;
        be_wr_ready_i = 1'b0;
        be_rep_done_i = 1'b0;
        @(negedge clk);
        check_eq("idle_be_wr_valid",  be_wr_valid_o,  0);
        check_eq("idle_be_rep_valid", be_rep_valid_o, 0);
        check_eq("idle_starve",       starve_cnt_o,   model_starve);

        exp_g = predict(wv, rv, wa, ra);
        if (exp_g == 1) model_starve = 0;
        else if (exp_g == 2 && wv && model_starve < MAX_WAIT) model_starve++;

        h      = (exp_g == 0) ? 0 : hold;
        grant  = 0;
        starve = 0;
        for (int k = 0; k <= h; k++) begin
            @(posedge clk); #1;
            if (noise) begin
                if (exp_g != 0) begin
                    wr_valid_i  = 1'($urandom % 2);
                    rep_valid_i = 1'($urandom % 2);
                end
                be_wr_ready_i = (exp_g != 1) ? 1'($urandom % 2) : 1'b0;
                be_rep_done_i = (exp_g != 2) ? 1'($urandom % 2) : 1'b0;
            end
            if (k == h && exp_g == 1) be_wr_ready_i = 1'b1;
            if (k == h && exp_g == 2) be_rep_done_i = 1'b1;
            @(negedge clk);
            if (k == 0) begin
                grant  = observed_grant();
                starve = int'(starve_cnt_o);
                check_eq("grant",        grant, exp_g);
                check_eq("grant_starve", starve_cnt_o, model_starve);
                check_eq("onehot",       be_wr_valid_o & be_rep_valid_o, 0);
            end else begin
                check_eq("grant_held", observed_grant(), exp_g);
            end
            check_eq("wr_ready",  wr_ready_o, (k == h && exp_g == 1) ? 1 : 0);
            check_eq("rep_done",  rep_done_o, (k == h && exp_g == 2) ? 1 : 0);
        end
    endtask

    initial begin
        int g;
        int s;
        int exp_g;
        int ord_g [4] = '{2, 2, 1, 2};
        int ord_s [4] = '{1, 2, 0, 1};
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] ra;
        bit wv;
        bit rv;

        rst_i         = 1'b1;
        wr_valid_i    = 1'b0;
        rep_valid_i   = 1'b0;
        wr_addr_i     = '0;
        rep_addr_i    = '0;
        be_wr_ready_i = 1'b0;
        be_rep_done_i = 1'b0;

        // Reset state
        #12;
        check_eq("rst_be_wr_valid",  be_wr_valid_o,  0);
        check_eq("rst_be_rep_valid", be_rep_valid_o, 0);
        check_eq("rst_starve",       starve_cnt_o,   0);
        check_eq("rst_wr_ready",     wr_ready_o,     0);
        check_eq("rst_rep_done",     rep_done_o,     0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(posedge clk);

        // Both valid, distinct lines, count at zero: replace wins, count 1
        txn(1'b1, 1'b1, 16'h0010, 16'h0020, 1, 1'b0, g, s);
        check_eq("both_grant",  g, 2);
        check_eq("both_starve", s, 1);

        // Write only: grant after one cycle, completion five cycles in
        txn(1'b1, 1'b0, 16'h0030, 16'h0040, 4, 1'b0, g, s);
        check_eq("wr_only_grant",  g, 1);
        check_eq("wr_only_starve", s, 0);

        // Continuous contention with MAX_WAIT=2
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 16'h0100, 16'h0200, 1, 1'b0, g, s);
            check_eq("order_grant",  g, ord_g[i]);
            check_eq("order_starve", s, ord_s[i]);
        end

        // Same line on both sides with a zero count
        txn(1'b1, 1'b0, 16'h0001, 16'h0002, 0, 1'b0, g, s);
        txn(1'b1, 1'b1, 16'h1234, 16'h1234, 1, 1'b0, g, s);
`ifdef IOB_CACHE_BE_ARB_HAZARD_EN
        check_eq("hazard_grant", g, 1);
`else
        check_eq("hazard_grant", g, 2);
`endif

        // Reset while a replacement is outstanding
        @(posedge clk); #1;
        wr_valid_i    = 1'b1;
        rep_valid_i   = 1'b1;
        wr_addr_i     = 16'h0001;
        rep_addr_i    = 16'h0002;
        be_wr_ready_i = 1'b0;
        be_rep_done_i = 1'b0;
        exp_g = predict(1'b1, 1'b1, 16'h0001, 16'h0002);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("abort_pre_grant", observed_grant(), exp_g);
        #2;
        rst_i = 1'b1;
        #1;
        model_starve = 0;
        check_eq("abort_be_rep_valid", be_rep_valid_o, 0);
        check_eq("abort_be_wr_valid",  be_wr_valid_o,  0);
        check_eq("abort_starve",       starve_cnt_o,   0);
        check_eq("abort_rep_done",     rep_done_o,     0);
        be_rep_done_i = 1'b1;
        wr_valid_i    = 1'b0;
        #1;
        check_eq("abort_done_in_rst", rep_done_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_eq("late_done_ignored", rep_done_o, 0);
        @(posedge clk); #1;
        be_rep_done_i = 1'b0;
        @(negedge clk);
        check_eq("first_edge_no_grant", be_rep_valid_o, 0);
        @(posedge clk); #1;
        be_rep_done_i = 1'b1;
        rep_valid_i   = 1'b0;
        @(negedge clk);
        check_eq("second_edge_grant",  be_rep_valid_o, 1);
        check_eq("second_edge_done",   rep_done_o,     1);
        check_eq("second_edge_starve", starve_cnt_o,   0);

        // Randomized rounds
        repeat (300) begin
            wv = 1'($urandom % 2);
            rv = 1'($urandom % 2);
            wa = ADDR_W'($urandom);
            ra = (($urandom % 4) == 0) ? wa : ADDR_W'($urandom);
            txn(wv, rv, wa, ra, int'($urandom % 4), 1'b1, g, s);
        end

        @(posedge clk); #1;
        wr_valid_i    = 1'b0;
        rep_valid_i   = 1'b0;
        be_wr_ready_i = 1'b0;
        be_rep_done_i = 1'b0;
        @(negedge clk);
        check_eq("final_idle", observed_grant(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
